pattern_sequencer: RTL and testbench

//   Configuration controller for the video pattern generator. Picks the active

---
 rtl/pattern_sequencer_if.sv | 37 +++
 rtl/pattern_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_pattern_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_sequencer_if.sv
// Bus between the pattern sequencer and its surroundings: frame timing, button/auto
// inputs and the config outputs. Force signals exist only with PATTERN_SEQ_FORCE_EN.
interface pattern_sequencer_if #(
  parameter int X_BITS = 13,
  parameter int STEP_W = 9
);
  logic              vs_in;
  logic              btn_next;
  logic              auto_en;
  logic [X_BITS-1:0] total_active_pix;
  logic [7:0]        pattern_out;
  logic [STEP_W-1:0] ramp_step_out;
  logic              cfg_update;
  logic              busy;
`ifdef PATTERN_SEQ_FORCE_EN
  logic              force_en;
  logic [7:0]        force_pattern;

  modport master (
    output vs_in, btn_next, auto_en, total_active_pix, force_en, force_pattern,
    input  pattern_out, ramp_step_out, cfg_update, busy
  );
  modport slave (
    input  vs_in, btn_next, auto_en, total_active_pix, force_en, force_pattern,
    output pattern_out, ramp_step_out, cfg_update, busy
  );
`else
  modport master (
    output vs_in, btn_next, auto_en, total_active_pix,
    input  pattern_out, ramp_step_out, cfg_update, busy
  );
  modport slave (
    input  vs_in, btn_next, auto_en, total_active_pix,
    output pattern_out, ramp_step_out, cfg_update, busy
  );
`endif
endinterface

// File: rtl/pattern_sequencer.sv
// Pattern/ramp-step controller for the video pattern generator, applied on vsync start.
// Optional PATTERN_SEQ_FORCE_EN adds a forced pattern select (force_en/force_pattern).
module pattern_sequencer #(
  parameter int B                  = 8,
  parameter int X_BITS             = 13,
  parameter int FRACTIONAL_BITS    = 1,
  parameter int NUM_PATTERNS       = 5,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int DEBOUNCE_CYCLES    = 1000000,
  parameter int VS_ACTIVE_HIGH     = 0
) (
  input  logic               clk_in,
  input  logic               reset,
  pattern_sequencer_if.slave bus_io
);
  localparam int STEP_W = B + FRACTIONAL_BITS;
  localparam int DIV_N  = STEP_W + 1;
  localparam int CNT_W  = $clog2(DIV_N);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FR_W   = $clog2(FRAMES_PER_PATTERN + 1);

  localparam logic [DB_W-1:0]   DB_RELOAD = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FR_W-1:0]   FR_LAST   = FR_W'(FRAMES_PER_PATTERN - 1);
  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(STEP_W);
  localparam logic [7:0]        PAT_LAST  = 8'(NUM_PATTERNS - 1);
  localparam logic [STEP_W-1:0] STEP_MAX  = '1;
  localparam logic              VS_IDLE   = (VS_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_PEND} state_t;

  logic              vs_q, vs_d1_q;
  logic              fs;
  logic              btn_s1_q, btn_s2_q, btn_stable_q, btn_req_q;
  logic [DB_W-1:0]   db_cnt_q;
  logic [FR_W-1:0]   frame_cnt_q;
  logic              auto_req, force_req, req;

  state_t            state_q;
  logic [X_BITS-1:0] div_q;
  logic [CNT_W-1:0]  div_cnt_q;
  logic [X_BITS-1:0] rem_q;
  logic [STEP_W-1:0] quo_q;
  logic [STEP_W-1:0] step_q;
  logic              boot_q;
  logic [7:0]        pattern_q;
  logic [STEP_W-1:0] ramp_q;
  logic              cfg_update_q;
  logic              busy_q;

  logic [X_BITS:0]   rem_sh;
  logic              q_bit;
  logic [X_BITS-1:0] rem_d;
  logic [DIV_N-1:0]  quo_d;
  logic [STEP_W-1:0] step_d;
  logic [7:0]        pattern_d;

  // Frame start: first registered sample at the active vsync level.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      vs_q    <= VS_IDLE;
      vs_d1_q <= VS_IDLE;
    end else begin
      vs_q    <= bus_io.vs_in;
      vs_d1_q <= vs_q;
    end
  end

  assign fs = (VS_ACTIVE_HIGH != 0) ? (vs_q & ~vs_d1_q) : (~vs_q & vs_d1_q);

  // Debounce: down-counter reloads while the synced level matches the accepted one.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      btn_s1_q     <= 1'b0;
      btn_s2_q     <= 1'b0;
      btn_stable_q <= 1'b0;
      btn_req_q    <= 1'b0;
      db_cnt_q     <= DB_RELOAD;
    end else begin
      btn_s1_q  <= bus_io.btn_next;
      btn_s2_q  <= btn_s1_q;
      btn_req_q <= 1'b0;
      if (btn_s2_q == btn_stable_q) begin
        db_cnt_q <= DB_RELOAD;
      end else if (db_cnt_q == '0) begin
        btn_stable_q <= btn_s2_q;
        btn_req_q    <= btn_s2_q;
        db_cnt_q     <= DB_RELOAD;
      end else begin
        db_cnt_q <= db_cnt_q - 1'b1;
      end
    end
  end

  // Saturates at the trigger count so a long auto_en=0 stretch cannot wrap past it.
  always_ff @(posedge clk_in) begin
    if (reset || cfg_update_q) begin
      frame_cnt_q <= '0;
    end else if (fs && (frame_cnt_q != FR_LAST)) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign auto_req = fs & bus_io.auto_en & (frame_cnt_q == FR_LAST);

`ifdef PATTERN_SEQ_FORCE_EN
  logic force_en_q;

  always_ff @(posedge clk_in) begin
    if (reset) force_en_q <= 1'b0;
    else       force_en_q <= bus_io.force_en;
  end

  assign force_req = bus_io.force_en & ~force_en_q;
`else
  assign force_req = 1'b0;
`endif

  assign req = btn_req_q | auto_req | force_req;

  // One restoring-divide step; dividend 2^STEP_W has only its MSB set.
  assign rem_sh = {rem_q, (div_cnt_q == DIV_LAST)};
  assign q_bit  = (rem_sh >= {1'b0, div_q});
  assign rem_d  = X_BITS'(q_bit ? (rem_sh - {1'b0, div_q}) : rem_sh);
  assign quo_d  = {quo_q, q_bit};

  always_comb begin
    step_d = quo_d[STEP_W-1:0];
    if ((div_q == '0) || quo_d[STEP_W]) begin
      step_d = STEP_MAX;
    end else if (quo_d[STEP_W-1:0] == '0) begin
      step_d = STEP_W'(1);
    end
  end

  always_comb begin
    pattern_d = pattern_q;
    if (!boot_q) begin
      pattern_d = (pattern_q >= PAT_LAST) ? 8'd0 : pattern_q + 8'd1;
    end
`ifdef PATTERN_SEQ_FORCE_EN
    if (bus_io.force_en) begin
      pattern_d = (bus_io.force_pattern > PAT_LAST) ? PAT_LAST : bus_io.force_pattern;
    end
`endif
  end

  // state  | meaning
  // IDLE   | outputs stable, waiting for a button/auto/force request
  // CALC   | STEP_W+1 divide cycles on the latched width
  // PEND   | step ready, waiting for the next frame start to apply
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= S_CALC;
      div_q        <= bus_io.total_active_pix;
      div_cnt_q    <= DIV_LAST;
      rem_q        <= '0;
      quo_q        <= '0;
      step_q       <= STEP_W'(1);
      boot_q       <= 1'b1;
      pattern_q    <= 8'd0;
      ramp_q       <= STEP_W'(1);
      cfg_update_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      cfg_update_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            state_q   <= S_CALC;
            div_q     <= bus_io.total_active_pix;
            div_cnt_q <= DIV_LAST;
            rem_q     <= '0;
            quo_q     <= '0;
            busy_q    <= 1'b1;
          end
        end
        S_CALC: begin
          rem_q     <= rem_d;
          quo_q     <= quo_d[STEP_W-1:0];
          div_cnt_q <= div_cnt_q - 1'b1;
          if (div_cnt_q == '0) begin
            step_q  <= step_d;
            state_q <= S_PEND;
          end
        end
        S_PEND: begin
          if (fs) begin
            ramp_q       <= step_q;
            pattern_q    <= pattern_d;
            boot_q       <= 1'b0;
            cfg_update_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_io.pattern_out   = pattern_q;
  assign bus_io.ramp_step_out = ramp_q;
  assign bus_io.cfg_update    = cfg_update_q;
  assign bus_io.busy          = busy_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: boot apply, ramp divide, debounce, auto advance,
// request collisions and reset abort. Force select checked when PATTERN_SEQ_FORCE_EN is set.
module tb_pattern_sequencer;
  localparam int X_BITS = 13;
  localparam int STEP_W = 9;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   upd_cnt = 0;
  int   wide_cnt = 0;
  int   off_fs_cnt = 0;
  logic upd_prev = 1'b0;

  pattern_sequencer_if #(.X_BITS(X_BITS), .STEP_W(STEP_W)) bus_if ();

  pattern_sequencer #(
    .B(8), .X_BITS(X_BITS), .FRACTIONAL_BITS(1), .NUM_PATTERNS(5),
    .FRAMES_PER_PATTERN(3), .DEBOUNCE_CYCLES(16), .VS_ACTIVE_HIGH(0)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus_io (bus_if.slave)
  );

  always #5 clk_in = ~clk_in;

  // Track cfg_update pulses, their width and whether they land inside the vsync pulse.
  always @(posedge clk_in) begin
    #2;
    if (bus_if.cfg_update === 1'b1) begin
      upd_cnt++;
      if (upd_prev) wide_cnt++;
      if (bus_if.vs_in !== 1'b0) off_fs_cnt++;
    end
    upd_prev = bus_if.cfg_update;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want finish before limit");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic frame();
    bus_if.vs_in = 1'b0;
    cyc(4);
    bus_if.vs_in = 1'b1;
    cyc(16);
  endtask

  task automatic press(input int len);
    bus_if.btn_next = 1'b1;
    cyc(len);
    bus_if.btn_next = 1'b0;
  endtask

  task automatic do_reset(input logic [X_BITS-1:0] pix);
    reset = 1'b1;
    bus_if.total_active_pix = pix;
    bus_if.vs_in    = 1'b1;
    bus_if.btn_next = 1'b0;
    bus_if.auto_en  = 1'b0;
`ifdef PATTERN_SEQ_FORCE_EN
    bus_if.force_en      = 1'b0;
    bus_if.force_pattern = 8'd0;
`endif
    cyc(3);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int u0;
    do_reset(13'd100);
    reset = 1'b1;
    cyc(1);
    vec_cnt++; if (bus_if.pattern_out !== 8'd0) begin err_cnt++; $display("FAIL reset_pattern: got %0d want 0", bus_if.pattern_out); end
    vec_cnt++; if (bus_if.ramp_step_out !== 9'd1) begin err_cnt++; $display("FAIL reset_ramp: got %0d want 1", bus_if.ramp_step_out); end
    vec_cnt++; if (bus_if.cfg_update !== 1'b0) begin err_cnt++; $display("FAIL reset_cfg_update: got %b want 0", bus_if.cfg_update); end
    vec_cnt++; if (bus_if.busy !== 1'b1) begin err_cnt++; $display("FAIL reset_busy: got %b want 1", bus_if.busy); end
    reset = 1'b0;
    u0 = upd_cnt;
    cyc(2);
    vec_cnt++; if (bus_if.busy !== 1'b1) begin err_cnt++; $display("FAIL boot_busy_calc: got %b want 1", bus_if.busy); end
    cyc(15);
    vec_cnt++; if (bus_if.busy !== 1'b1) begin err_cnt++; $display("FAIL boot_busy_pend: got %b want 1", bus_if.busy); end
    vec_cnt++; if (bus_if.ramp_step_out !== 9'd1) begin err_cnt++; $display("FAIL boot_ramp_early: got %0d want 1", bus_if.ramp_step_out); end
    vec_cnt++; if (upd_cnt - u0 != 0) begin err_cnt++; $display("FAIL boot_no_update_before_fs: got %0d want 0", upd_cnt - u0); end
    frame();
    vec_cnt++; if (upd_cnt - u0 != 1) begin err_cnt++; $display("FAIL boot_update_count: got %0d want 1", upd_cnt - u0); end
    vec_cnt++; if (bus_if.pattern_out !== 8'd0) begin err_cnt++; $display("FAIL boot_pattern: got %0d want 0", bus_if.pattern_out); end
    vec_cnt++; if (bus_if.ramp_step_out !== 9'd5) begin err_cnt++; $display("FAIL boot_ramp: got %0d want 5", bus_if.ramp_step_out); end
    vec_cnt++; if (bus_if.busy !== 1'b0) begin err_cnt++; $display("FAIL boot_busy_after: got %b want 0", bus_if.busy); end
  endtask

  task automatic test_ramp();
    int pix_tab[10] = '{1, 0, 2, 3, 100, 200, 511, 512, 1920, 8191};
    int exp_tab[10] = '{511, 511, 256, 170, 5, 2, 1, 1, 1, 1};
    logic [8:0] exp_step;
    int u0;
    for (int i = 0; i < 10; i++) begin
      do_reset(13'(pix_tab[i]));
      cyc(15);
      u0 = upd_cnt;
      frame();
      exp_step = 9'(exp_tab[i]);
      vec_cnt++; if (upd_cnt - u0 != 1) begin err_cnt++; $display("FAIL ramp_update pix=%0d: got %0d want 1", pix_tab[i], upd_cnt - u0); end
      vec_cnt++; if (bus_if.ramp_step_out !== exp_step) begin err_cnt++; $display("FAIL ramp_step pix=%0d: got %0d want %0d", pix_tab[i], bus_if.ramp_step_out, exp_step); end
    end
  endtask

  task automatic test_debounce_short();
    int lens[3] = '{1, 8, 15};
    int u0;
    do_reset(13'd100);
    cyc(15);
    frame();
    u0 = upd_cnt;
    for (int i = 0; i < 3; i++) begin
      press(lens[i]);
      cyc(30);
    end
    vec_cnt++; if (bus_if.busy !== 1'b0) begin err_cnt++; $display("FAIL short_press_busy: got %b want 0", bus_if.busy); end
    frame();
    vec_cnt++; if (upd_cnt - u0 != 0) begin err_cnt++; $display("FAIL short_press_update: got %0d want 0", upd_cnt - u0); end
    vec_cnt++; if (bus_if.pattern_out !== 8'd0) begin err_cnt++; $display("FAIL short_press_pattern: got %0d want 0", bus_if.pattern_out); end
  endtask

  task automatic test_button();
    int u0;
    u0 = upd_cnt;
    bus_if.total_active_pix = 13'd200;
    press(20);
    cyc(40);
    bus_if.total_active_pix = 13'd1;
    vec_cnt++; if (bus_if.busy !== 1'b1) begin err_cnt++; $display("FAIL button_busy_pend: got %b want 1", bus_if.busy); end
    vec_cnt++; if (bus_if.pattern_out !== 8'd0) begin err_cnt++; $display("FAIL button_pattern_early: got %0d want 0", bus_if.pattern_out); end
    frame();
    vec_cnt++; if (upd_cnt - u0 != 1) begin err_cnt++; $display("FAIL button_update: got %0d want 1", upd_cnt - u0); end
    vec_cnt++; if (bus_if.pattern_out !== 8'd1) begin err_cnt++; $display("FAIL button_pattern: got %0d want 1", bus_if.pattern_out); end
    vec_cnt++; if (bus_if.ramp_step_out !== 9'd2) begin err_cnt++; $display("FAIL button_ramp_latched: got %0d want 2", bus_if.ramp_step_out); end
    frame();
    vec_cnt++; if (upd_cnt - u0 != 1) begin err_cnt++; $display("FAIL button_single: got %0d want 1", upd_cnt - u0); end
  endtask

  task automatic test_press_in_pend();
    int u0;
    u0 = upd_cnt;
    bus_if.total_active_pix = 13'd100;
    press(20);
    cyc(40);
    press(20);
    cyc(40);
    frame();
    vec_cnt++; if (upd_cnt - u0 != 1) begin err_cnt++; $display("FAIL pend_press_update: got %0d want 1", upd_cnt - u0); end
    vec_cnt++; if (bus_if.pattern_out !== 8'd2) begin err_cnt++; $display("FAIL pend_press_pattern: got %0d want 2", bus_if.pattern_out); end
    frame();
    vec_cnt++; if (upd_cnt - u0 != 1) begin err_cnt++; $display("FAIL pend_press_not_queued: got %0d want 1", upd_cnt - u0); end
  endtask

  // Press at cycle 0 reaches the FSM at edge 19; divide edges run 20..29.
  task automatic test_fs_in_calc();
    int lags[3]   = '{23, 27, 28};
    int exp_up[3] = '{0, 0, 1};
    int exp_p;
    int u0;
    exp_p = int'(bus_if.pattern_out);
    for (int i = 0; i < 3; i++) begin
      u0 = upd_cnt;
      for (int c = 0; c < 60; c++) begin
        if (c == 0)           bus_if.btn_next = 1'b1;
        if (c == 20)          bus_if.btn_next = 1'b0;
        if (c == lags[i])     bus_if.vs_in = 1'b0;
        if (c == lags[i] + 4) bus_if.vs_in = 1'b1;
        @(negedge clk_in);
      end
      vec_cnt++; if (upd_cnt - u0 != exp_up[i]) begin err_cnt++; $display("FAIL fs_calc_lag%0d: got %0d want %0d", lags[i], upd_cnt - u0, exp_up[i]); end
      if (exp_up[i] == 0) frame();
      exp_p = (exp_p + 1) % 5;
      vec_cnt++; if (upd_cnt - u0 != 1) begin err_cnt++; $display("FAIL fs_calc_apply_lag%0d: got %0d want 1", lags[i], upd_cnt - u0); end
      vec_cnt++; if (bus_if.pattern_out !== 8'(exp_p)) begin err_cnt++; $display("FAIL fs_calc_pattern_lag%0d: got %0d want %0d", lags[i], bus_if.pattern_out, exp_p); end
    end
  endtask

  task automatic test_auto();
    int u0;
    int exp_p;
    int exp_up;
    do_reset(13'd100);
    cyc(15);
    frame();
    bus_if.auto_en = 1'b1;
    exp_p = 0;
    for (int f = 1; f <= 20; f++) begin
      u0 = upd_cnt;
      frame();
      exp_up = (f % 4 == 0) ? 1 : 0;
      if (exp_up == 1) exp_p = (exp_p + 1) % 5;
      vec_cnt++; if (upd_cnt - u0 != exp_up) begin err_cnt++; $display("FAIL auto_update f=%0d: got %0d want %0d", f, upd_cnt - u0, exp_up); end
      vec_cnt++; if (bus_if.pattern_out !== 8'(exp_p)) begin err_cnt++; $display("FAIL auto_pattern f=%0d: got %0d want %0d", f, bus_if.pattern_out, exp_p); end
    end
    bus_if.auto_en = 1'b0;
  endtask

  // Button press timed so btn_req and auto_req hit the FSM on the same edge.
  task automatic test_back_to_back();
    int u0;
    do_reset(13'd100);
    cyc(15);
    frame();
    bus_if.auto_en = 1'b1;
    frame();
    frame();
    u0 = upd_cnt;
    for (int c = 0; c < 40; c++) begin
      if (c == 0)  bus_if.btn_next = 1'b1;
      if (c == 17) bus_if.vs_in = 1'b0;
      if (c == 20) bus_if.btn_next = 1'b0;
      if (c == 21) bus_if.vs_in = 1'b1;
      @(negedge clk_in);
    end
    vec_cnt++; if (bus_if.busy !== 1'b1) begin err_cnt++; $display("FAIL collide_busy: got %b want 1", bus_if.busy); end
    frame();
    vec_cnt++; if (upd_cnt - u0 != 1) begin err_cnt++; $display("FAIL collide_update: got %0d want 1", upd_cnt - u0); end
    vec_cnt++; if (bus_if.pattern_out !== 8'd1) begin err_cnt++; $display("FAIL collide_pattern: got %0d want 1", bus_if.pattern_out); end
    frame();
    vec_cnt++; if (upd_cnt - u0 != 1) begin err_cnt++; $display("FAIL collide_no_second: got %0d want 1", upd_cnt - u0); end
    bus_if.auto_en = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    int u0;
    bus_if.total_active_pix = 13'd200;
    press(20);
    cyc(1);
    reset = 1'b1;
    cyc(3);
    vec_cnt++; if (bus_if.pattern_out !== 8'd0) begin err_cnt++; $display("FAIL abort_pattern: got %0d want 0", bus_if.pattern_out); end
    vec_cnt++; if (bus_if.ramp_step_out !== 9'd1) begin err_cnt++; $display("FAIL abort_ramp: got %0d want 1", bus_if.ramp_step_out); end
    vec_cnt++; if (bus_if.busy !== 1'b1) begin err_cnt++; $display("FAIL abort_busy: got %b want 1", bus_if.busy); end
    reset = 1'b0;
    u0 = upd_cnt;
    cyc(15);
    vec_cnt++; if (upd_cnt - u0 != 0) begin err_cnt++; $display("FAIL abort_no_early_update: got %0d want 0", upd_cnt - u0); end
    frame();
    vec_cnt++; if (upd_cnt - u0 != 1) begin err_cnt++; $display("FAIL abort_boot_update: got %0d want 1", upd_cnt - u0); end
    vec_cnt++; if (bus_if.pattern_out !== 8'd0) begin err_cnt++; $display("FAIL abort_boot_pattern: got %0d want 0", bus_if.pattern_out); end
    vec_cnt++; if (bus_if.ramp_step_out !== 9'd2) begin err_cnt++; $display("FAIL abort_boot_ramp: got %0d want 2", bus_if.ramp_step_out); end
  endtask

`ifdef PATTERN_SEQ_FORCE_EN
  task automatic test_force();
    int u0;
    do_reset(13'd100);
    cyc(15);
    frame();
    u0 = upd_cnt;
    bus_if.force_pattern = 8'd9;
    bus_if.force_en = 1'b1;
    cyc(30);
    frame();
    vec_cnt++; if (upd_cnt - u0 != 1) begin err_cnt++; $display("FAIL force_update: got %0d want 1", upd_cnt - u0); end
    vec_cnt++; if (bus_if.pattern_out !== 8'd4) begin err_cnt++; $display("FAIL force_clamp: got %0d want 4", bus_if.pattern_out); end
    bus_if.force_en = 1'b0;
    cyc(5);
    bus_if.force_pattern = 8'd2;
    bus_if.force_en = 1'b1;
    cyc(30);
    frame();
    vec_cnt++; if (bus_if.pattern_out !== 8'd2) begin err_cnt++; $display("FAIL force_load: got %0d want 2", bus_if.pattern_out); end
    bus_if.force_en = 1'b0;
  endtask
`endif

  initial begin
    bus_if.vs_in = 1'b1;
    bus_if.btn_next = 1'b0;
    bus_if.auto_en = 1'b0;
    bus_if.total_active_pix = 13'd100;
`ifdef PATTERN_SEQ_FORCE_EN
    bus_if.force_en = 1'b0;
    bus_if.force_pattern = 8'd0;
`endif
    test_reset();
    test_ramp();
    test_debounce_short();
    test_button();
    test_press_in_pend();
    test_fs_in_calc();
    test_auto();
    test_back_to_back();
    test_reset_mid_calc();
`ifdef PATTERN_SEQ_FORCE_EN
    test_force();
`endif
    vec_cnt++; if (wide_cnt != 0) begin err_cnt++; $display("FAIL cfg_update_width: got %0d wide pulses want 0", wide_cnt); end
    vec_cnt++; if (off_fs_cnt != 0) begin err_cnt++; $display("FAIL cfg_update_off_fs: got %0d pulses outside vsync want 0", off_fs_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
